// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - yellow-phase timer, car-request debounce and gating for the traffic light FSM
module traffic_phase_timer #(
  parameter int TICKS_PER_SEC   = 100,
  parameter int YELLOW_SEC      = 3,
  parameter int MIN_GREEN_SEC   = 10,
  parameter int MAX_LANE_SEC    = 20,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] highway,
  input  logic [1:0] lane,
  input  logic       car_raw,
  output logic       sensor,
  output logic       delay_3sec,
  output logic       fault
);

  localparam int MAX_AB  = (YELLOW_SEC > MIN_GREEN_SEC) ? YELLOW_SEC : MIN_GREEN_SEC;
  localparam int SEC_SAT = (MAX_AB > MAX_LANE_SEC) ? MAX_AB : MAX_LANE_SEC;
  localparam int SW      = $clog2(SEC_SAT) + 1;
  localparam int PW      = $clog2(TICKS_PER_SEC);
  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0] PRESC_LAST   = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_PRE    = PW'(TICKS_PER_SEC - 2);
  localparam logic [SW-1:0] SEC_MAX      = SW'(SEC_SAT);
  localparam logic [SW-1:0] SEC_YEL_LAST = SW'(YELLOW_SEC - 1);
  localparam logic [SW-1:0] SEC_MIN_GRN  = SW'(MIN_GREEN_SEC);
  localparam logic [SW-1:0] SEC_MAX_LANE = SW'(MAX_LANE_SEC);
  localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {HW_GREEN, YELLOW, WAIT, LANE_GREEN, FAULT} state_t;

  function automatic state_t decode(input logic [3:0] l);
    case (l)
      4'b0010:          decode = HW_GREEN;
      4'b0110, 4'b1001: decode = YELLOW;
      4'b1000:          decode = LANE_GREEN;
      default:          decode = FAULT;
    endcase
  endfunction

  state_t        state, state_next;
  logic [3:0]    lights, lights_q;
  logic          change;
  logic [PW-1:0] presc, presc_next;
  logic [SW-1:0] sec, sec_next;
  logic          deb, deb_next;
  logic [DW-1:0] deb_cnt, deb_cnt_next;
  logic          sensor_next, pulse_next, fault_next;

  assign lights = {highway, lane};
  assign change = (lights != lights_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HW_GREEN;
      lights_q   <= 4'b0010;
      presc      <= '0;
      sec        <= '0;
      deb        <= 1'b0;
      deb_cnt    <= '0;
      sensor     <= 1'b0;
      delay_3sec <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_next;
      lights_q   <= lights;
      presc      <= presc_next;
      sec        <= sec_next;
      deb        <= deb_next;
      deb_cnt    <= deb_cnt_next;
      sensor     <= sensor_next;
      delay_3sec <= pulse_next;
      fault      <= fault_next;
    end
  end

  always_comb begin
    state_next = state;
    pulse_next = 1'b0;
    presc_next = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    sec_next   = sec;
    if (presc == PRESC_LAST && sec != SEC_MAX)
      sec_next = sec + SW'(1);

    if (change) begin
      state_next = decode(lights);
      presc_next = '0;
      sec_next   = '0;
    end else if (state == YELLOW && sec == SEC_YEL_LAST && presc == PRESC_PRE) begin
      // Fire one cycle early so the registered pulse lands exactly YELLOW_SEC seconds after the change
      pulse_next = 1'b1;
      state_next = WAIT;
    end

    case (state)
      HW_GREEN:     sensor_next = deb && (sec >= SEC_MIN_GRN);
      YELLOW, WAIT: sensor_next = deb;
      LANE_GREEN:   sensor_next = deb && (sec < SEC_MAX_LANE);
      default:      sensor_next = 1'b0;
    endcase
    fault_next = (state == FAULT);

    deb_next     = deb;
    deb_cnt_next = '0;
    if (car_raw != deb) begin
      if (deb_cnt == DEB_LAST)
        deb_next = car_raw;
      else
        deb_cnt_next = deb_cnt + DW'(1);
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb/tb_traffic_phase_timer.sv - randomized and scenario bench for traffic_phase_timer against a cycle-count reference model
module tb_traffic_phase_timer;

  localparam int T    = 4;
  localparam int Y    = 3;
  localparam int MING = 2;
  localparam int MAXL = 5;
  localparam int D    = 3;
  localparam int SMAX = 5;

  localparam int K_HWG   = 0;
  localparam int K_YEL   = 1;
  localparam int K_LANE  = 2;
  localparam int K_FAULT = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] highway = 2'b00;
  logic [1:0] lane = 2'b10;
  logic       car_raw = 1'b0;
  logic       sensor, delay_3sec, fault;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .TICKS_PER_SEC(T), .YELLOW_SEC(Y), .MIN_GREEN_SEC(MING),
    .MAX_LANE_SEC(MAXL), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .highway(highway), .lane(lane),
    .car_raw(car_raw), .sensor(sensor), .delay_3sec(delay_3sec), .fault(fault)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time is measured in cycles since the last light change
  int         m_cyc, m_chg, m_kind, m_run;
  bit         m_fired, m_deb;
  logic [3:0] m_lights;
  bit         e_sensor, e_delay, e_fault;

  int pulse_cnt, pulse_cyc, first_hi, last_hi, low_cnt;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  function automatic int classify(input logic [1:0] h, input logic [1:0] l);
    if (h == 2'b00 && l == 2'b10) return K_HWG;
    if ((h == 2'b01 && l == 2'b10) || (h == 2'b10 && l == 2'b01)) return K_YEL;
    if (h == 2'b10 && l == 2'b00) return K_LANE;
    return K_FAULT;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_chg = -1; m_kind = K_HWG; m_run = 0;
    m_fired = 0; m_deb = 0; m_lights = 4'b0010;
    e_sensor = 0; e_delay = 0; e_fault = 0;
  endtask

  task automatic model_edge();
    int secs;
    secs = (m_cyc - m_chg - 1) / T;
    if (secs > SMAX) secs = SMAX;
    case (m_kind)
      K_HWG:   e_sensor = m_deb && (secs >= MING);
      K_YEL:   e_sensor = m_deb;
      K_LANE:  e_sensor = m_deb && (secs < MAXL);
      default: e_sensor = 0;
    endcase
    e_fault = (m_kind == K_FAULT);
    if ({highway, lane} != m_lights) begin
      m_chg = m_cyc; m_kind = classify(highway, lane); m_fired = 0; e_delay = 0;
    end else begin
      e_delay = (m_kind == K_YEL) && !m_fired && (m_cyc + 1 == m_chg + Y * T);
      if (e_delay) m_fired = 1;
    end
    m_lights = {highway, lane};
    if (car_raw != m_deb) begin
      m_run++;
      if (m_run == D) begin m_deb = car_raw; m_run = 0; end
    end else m_run = 0;
    m_cyc++;
  endtask

  task automatic clear_trackers();
    pulse_cnt = 0; pulse_cyc = -1; first_hi = -1; last_hi = -1; low_cnt = 0;
  endtask

  task automatic step(input logic [1:0] h, input logic [1:0] l, input logic c);
    highway = h; lane = l; car_raw = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("sensor", sensor, e_sensor);
    check("delay_3sec", delay_3sec, e_delay);
    check("fault", fault, e_fault);
    if (delay_3sec) begin pulse_cnt++; pulse_cyc = m_cyc; end
    if (sensor) begin
      if (first_hi < 0) first_hi = m_cyc;
      last_hi = m_cyc;
    end else low_cnt++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("reset_sensor", sensor, 0);
    check("reset_delay", delay_3sec, 0);
    check("reset_fault", fault, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int c, hold, car_hold, r;
    logic [1:0] h, l;
    logic car;

    #2;
    do_reset();

    clear_trackers();
    for (int i = 0; i < 14; i++) step(2'b00, 2'b10, 1'b1);
    check("min_green_rise", first_hi, 9);
    check("min_green_hold", last_hi, m_cyc);

    clear_trackers();
    c = m_cyc;
    for (int i = 0; i <= 42; i++) step(2'b01, 2'b10, 1'b1);
    check("yellow_pulse_cnt", pulse_cnt, 1);
    check("yellow_pulse_cyc", pulse_cyc, c + 12);

    for (int i = 0; i < 4; i++) step(2'b00, 2'b10, 1'b1);
    clear_trackers();
    c = m_cyc;
    for (int i = 0; i <= 40; i++) begin
      if (i < 7)      step(2'b01, 2'b10, 1'b1);
      else if (i < 9) step(2'b10, 2'b00, 1'b1);
      else            step(2'b10, 2'b01, 1'b1);
    end
    check("restart_pulse_cnt", pulse_cnt, 1);
    check("restart_pulse_cyc", pulse_cyc, c + 21);

    clear_trackers();
    c = m_cyc;
    for (int i = 0; i < 30; i++) step(2'b10, 2'b00, 1'b1);
    check("lane_first_hi", first_hi, c + 1);
    check("lane_last_hi", last_hi, c + 21);

    for (int i = 0; i < 15; i++) step(2'b00, 2'b10, 1'b1);
    clear_trackers();
    step(2'b00, 2'b10, 1'b0);
    step(2'b00, 2'b10, 1'b0);
    for (int i = 0; i < 6; i++) step(2'b00, 2'b10, 1'b1);
    check("glitch_no_drop", low_cnt, 0);
    clear_trackers();
    for (int i = 0; i < 6; i++) step(2'b00, 2'b10, 1'b0);
    check("debounce_drop", last_hi, c >= 0 ? m_cyc - 3 : 0);

    for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 1'b1);
    check("fault_set", fault, 1);
    check("fault_sensor", sensor, 0);
    for (int i = 0; i < 3; i++) step(2'b00, 2'b10, 1'b1);
    check("fault_clear", fault, 0);

    for (int i = 0; i < 6; i++) step(2'b01, 2'b10, 1'b0);
    do_reset();
    clear_trackers();
    for (int i = 0; i < 20; i++) step(2'b00, 2'b10, 1'b0);
    check("reset_no_pulse", pulse_cnt, 0);

    car = 1'b0;
    car_hold = 0;
    for (int s = 0; s < 80; s++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      begin h = 2'b00; l = 2'b10; end
      else if (r < 5) begin h = 2'b01; l = 2'b10; end
      else if (r < 6) begin h = 2'b10; l = 2'b01; end
      else if (r < 8) begin h = 2'b10; l = 2'b00; end
      else            begin h = 2'($urandom); l = 2'($urandom); end
      hold = $urandom_range(1, 45);
      for (int i = 0; i < hold; i++) begin
        if (car_hold == 0) begin car = ~car; car_hold = $urandom_range(1, 6); end
        car_hold--;
        step(h, l, car);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_timer.md
# traffic_phase_timer

Timing and sensor-conditioning companion to the traffic light FSM. It watches the FSM's `highway` and `lane` light outputs and generates the FSM's two inputs:
- `delay_3sec`: a single-cycle pulse when a yellow phase has lasted its full time.
- `sensor`: a debounced and policy-gated side-road car request.

It sits between the raw car detector, a free-running clock, and the FSM, closing the control loop.

## Interface
- `TICKS_PER_SEC`, 100 — clock cycles per second; must be ≥ 2.
- `YELLOW_SEC`, 3 — yellow phase length in seconds, counted from the light change to the `delay_3sec` pulse.
- `MIN_GREEN_SEC`, 10 — minimum highway-green seconds before `sensor` may assert.
- `MAX_LANE_SEC`, 20 — maximum lane-green seconds; after this, `sensor` is forced low.
- `DEBOUNCE_CYCLES`, 4 — consecutive stable cycles required to accept a `car_raw` change.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `highway`  in  2  highway light from the FSM: 00 green, 01 yellow, 10 red, 11 invalid.
- `lane`  in  2  lane light from the FSM, same encoding.
- `car_raw`  in  1  undebounced side-road detector.
- `sensor`  out  1  gated car request to the FSM.
- `delay_3sec`  out  1  one-cycle yellow-expired pulse to the FSM.
- `fault`  out  1  an invalid light combination is present.

## Operation
- **Light register and change detection.** `lights_q` registers {`highway`,`lane`} every cycle. A change is any cycle where {`highway`,`lane`} ≠ `lights_q`.
- **Prescaler.** Counts 0..`TICKS_PER_SEC`-1 and wraps. The terminal count produces an internal `sec_tick`.
- **Seconds counter.** Increments on `sec_tick` and saturates at max(`YELLOW_SEC`, `MIN_GREEN_SEC`, `MAX_LANE_SEC`). Width is `$clog2` of that maximum + 1.
- **On a light change:** the prescaler and seconds counter are cleared, and the state is re-decoded from the new lights. A change takes priority over a coincident `sec_tick`.
- **State decode:**
  - HW_GREEN: highway 00, lane 10.
  - YELLOW: exactly one road 01, the other 10.
  - LANE_GREEN: highway 10, lane 00.
  - FAULT: any other combination.
- **HW_GREEN:** `sensor` = `deb` & (seconds ≥ `MIN_GREEN_SEC`).
- **YELLOW:** `sensor` = `deb`. When the seconds counter reaches `YELLOW_SEC`, `delay_3sec` pulses for exactly one cycle and the state moves to WAIT.
- **WAIT:** no further pulses. `sensor` = `deb`. The state is left only on a light change.
- **LANE_GREEN:** `sensor` = `deb` & (seconds < `MAX_LANE_SEC`).
- **FAULT:** `sensor` = 0, `delay_3sec` = 0, `fault` = 1. The state is left on the next change to a valid combination.
- **Debounce.** `deb` is an internal registered value. It takes the value of `car_raw` only after `car_raw` has differed from `deb` for `DEBOUNCE_CYCLES` consecutive cycles. Any return to the `deb` value clears the stability count.
- All outputs are registered.

## Timing
- **Reset (async on `reset_n` = 0):**
  - `sensor` = 0, `delay_3sec` = 0, `fault` = 0.
  - `lights_q` = {00,10}; state HW_GREEN.
  - Prescaler, seconds counter, debounce count and `deb` = 0.
- **Reset release.** Timing starts on the first rising edge after `reset_n` rises. The reset state counts as the start of highway green.
- **`delay_3sec` latency.** If the lights change into yellow during cycle c, `delay_3sec` is high in exactly cycle c + `YELLOW_SEC`·`TICKS_PER_SEC`, and only in that cycle.
- **Change during the yellow count.** A light change before the pulse restarts the count; the pending pulse is not emitted.
- **`sensor` latency.** `sensor` reflects the gate conditions one cycle after they become true: registered output.
- **`deb` latency.** After `car_raw` settles at cycle c, `deb` updates at the end of cycle c + `DEBOUNCE_CYCLES` - 1.
- **Reset mid-yellow.** Outputs clear immediately and no pulse is produced.

## Test plan
All scenarios use `TICKS_PER_SEC`=4, `YELLOW_SEC`=3, `MIN_GREEN_SEC`=2, `MAX_LANE_SEC`=5, `DEBOUNCE_CYCLES`=3.

- **Min-green gating:** reset, then hold `car_raw`=1 from the first cycle with lights {00,10} → `sensor` stays 0 for 8 cycles, then rises and stays 1.
- **Yellow pulse:** change the lights to {01,10} at cycle c and hold → `delay_3sec` = 1 only in cycle c+12; no further pulse over the next 30 cycles.
- **Restart on change:** yellow entered at c, lights go {10,00} at c+7 and {10,01} at c+9 → single pulse at c+21, none at c+12.
- **Max lane green:** lights {10,00} with `car_raw`=1 throughout → `sensor` = 1 initially, drops to 0 after 20 cycles, stays 0.
- **Debounce:** `car_raw` 2-cycle glitch → `sensor` never changes; a held 3-cycle level → `deb` accepted.
- **Fault and reset:**
  - Lights {00,00} → `fault` = 1, `sensor` = 0; back to {00,10} → `fault` = 0.
  - `reset_n` low during the yellow count → all outputs 0 at once, no pulse.
